// File: rtl/modmul_check_pkg.sv
// Purpose : shared constants and types for the modular-arithmetic blocks (GCD/inverse producer, modmul consumer).
// Latency : n/a (package only).
// Backpressure: n/a.
//
// Contents:
//   DEFAULT_WIDTH : default operand/modulus width in bits
//   state_t       : modmul FSM state encoding
package modmul_check_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/modmul_step.sv
// Purpose : one interleaved shift-and-add step, acc' = (2*acc + bit*a) mod m.
// Latency : combinational.
// Backpressure: none; pure function of its inputs.
//
// Ports:
//   acc      : current accumulator, must be < m
//   a        : multiplicand, must be < m
//   m        : modulus
//   bit_in   : current multiplier bit
//   next_acc : reduced accumulator, always < m
module modmul_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] m,
  input  logic             bit_in,
  output logic [WIDTH-1:0] next_acc
);

  logic [WIDTH:0] m_ext;
  logic [WIDTH:0] dbl;
  logic [WIDTH:0] dbl_red;
  logic [WIDTH:0] sum;
  logic [WIDTH:0] sum_red;

  // acc < m and a < m keep every intermediate below 2m, which fits in
  // WIDTH+1 bits, so a single conditional subtract after each operation is
  // enough to bring the value back under m.
  always_comb begin
    m_ext   = {1'b0, m};
    dbl     = {acc, 1'b0};
    dbl_red = (dbl >= m_ext) ? (dbl - m_ext) : dbl;
    sum     = bit_in ? (dbl_red + {1'b0, a}) : dbl_red;
    sum_red = (sum >= m_ext) ? (sum - m_ext) : sum;
  end

  // Top bit of sum_red is always zero after reduction.
  assign next_acc = sum_red[WIDTH-1:0];

  logic unused_msb;
  assign unused_msb = sum_red[WIDTH];

endmodule

// File: rtl/modmul_check.sv
// Purpose : sequential (a*b) mod m, one multiplier bit per cycle MSB first; flags result==1 for inverse checks.
// Latency : WIDTH+1 cycles from accepted start to done (1 cycle on operand error).
// Backpressure: start is sampled only in IDLE; requests while busy or in DONE are dropped.
//
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   start          : operation request, honoured only in IDLE
//   data_a/b/m     : multiplicand, multiplier, modulus (captured on accept)
//   busy           : high during the WIDTH RUN cycles
//   done           : one-cycle pulse when result/is_one/err are valid
//   result, is_one : (a*b) mod m and (result == 1), held until next DONE
//   err            : operand check failed (m<2, a>=m or b>=m)
module modmul_check
  import modmul_check_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  input  logic [WIDTH-1:0] data_m,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             is_one,
  output logic             err
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

  state_t state_q;
  state_t state_d;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] m_q;
  logic [WIDTH-1:0] acc_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] step_acc;
  logic             op_ok;
  logic             last_bit;

  assign op_ok = (data_m >= WIDTH'(2)) && (data_a < data_m) && (data_b < data_m);
  assign last_bit = (cnt_q == '0);

  modmul_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .acc      (acc_q),
    .a        (a_q),
    .m        (m_q),
    .bit_in   (b_q[cnt_q]),
    .next_acc (step_acc)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a failed operand check skips RUN entirely.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = op_ok ? RUN : DONE;
        end
      end
      RUN: begin
        if (last_bit) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state_q)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // Operand capture, accumulator/counter and held result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      m_q    <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      result <= '0;
      is_one <= 1'b0;
      err    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            if (op_ok) begin
              a_q   <= data_a;
              b_q   <= data_b;
              m_q   <= data_m;
              acc_q <= '0;
              cnt_q <= CNT_INIT;
              err   <= 1'b0;
            end else begin
              err    <= 1'b1;
              result <= '0;
              is_one <= 1'b0;
            end
          end
        end
        RUN: begin
          acc_q <= step_acc;
          if (last_bit) begin
            result <= step_acc;
            is_one <= (step_acc == WIDTH'(1));
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: begin
          acc_q <= acc_q;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_modmul_check.sv
// Purpose : self-checking bench for modmul_check against an arithmetic (a*b)%m reference.
// Latency : checks WIDTH+1 cycle valid path and 1 cycle error path.
// Backpressure: checks that starts during RUN/DONE are dropped.
module tb_modmul_check;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] data_a = '0;
  logic [W-1:0] data_b = '0;
  logic [W-1:0] data_m = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         is_one;
  logic         err;

  int n_cmp = 0;
  int n_bad = 0;

  modmul_check #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .data_a (data_a),
    .data_b (data_b),
    .data_m (data_m),
    .busy   (busy),
    .done   (done),
    .result (result),
    .is_one (is_one),
    .err    (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer arithmetic.
  function automatic void ref_model(input int a, input int b, input int m,
                                    output int res, output int one, output int bad,
                                    output int lat);
    bad = (m < 2 || a >= m || b >= m) ? 1 : 0;
    res = bad ? 0 : (a * b) % m;
    one = (res == 1) ? 1 : 0;
    lat = bad ? 1 : W + 1;
  endfunction

  // Drives one request and observes it; no judging here.
  task automatic do_op(input int a, input int b, input int m,
                       output int lat, output int busy_cnt, output int res,
                       output int one, output int e);
    data_a = W'(a);
    data_b = W'(b);
    data_m = W'(m);
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = -1;
    busy_cnt = 0;
    res = -1;
    one = -1;
    e = -1;
    for (int i = 1; i <= 40; i++) begin
      if (done) begin
        lat = i;
        res = int'(result);
        one = int'(is_one);
        e = int'(err);
        break;
      end
      if (busy) busy_cnt++;
      tick();
    end
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    tick();
    tick();
    n_cmp++; if (busy !== 1'b0)  begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0)  begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (result !== '0)  begin n_bad++; $display("FAIL reset_result: got %0d want 0", result); end
    n_cmp++; if (is_one !== 1'b0) begin n_bad++; $display("FAIL reset_is_one: got %b want 0", is_one); end
    n_cmp++; if (err !== 1'b0)   begin n_bad++; $display("FAIL reset_err: got %b want 0", err); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_vectors();
    int va[9] = '{3, 3, 3, 200, 250, 7, 10, 0, 0};
    int vb[9] = '{5, 4, 5, 250, 250, 0, 3, 0, 5};
    int vm[9] = '{7, 11, 11, 251, 251, 13, 7, 1, 5};
    int lat, bc, res, one, e, x_res, x_one, x_bad, x_lat;
    for (int i = 0; i < 9; i++) begin
      ref_model(va[i], vb[i], vm[i], x_res, x_one, x_bad, x_lat);
      do_op(va[i], vb[i], vm[i], lat, bc, res, one, e);
      n_cmp++; if (lat !== x_lat) begin n_bad++; $display("FAIL vec%0d_latency: got %0d want %0d", i, lat, x_lat); end
      n_cmp++; if (bc !== (x_bad ? 0 : W)) begin n_bad++; $display("FAIL vec%0d_busy_cycles: got %0d want %0d", i, bc, x_bad ? 0 : W); end
      n_cmp++; if (res !== x_res) begin n_bad++; $display("FAIL vec%0d_result: got %0d want %0d", i, res, x_res); end
      n_cmp++; if (one !== x_one) begin n_bad++; $display("FAIL vec%0d_is_one: got %0d want %0d", i, one, x_one); end
      n_cmp++; if (e !== x_bad) begin n_bad++; $display("FAIL vec%0d_err: got %0d want %0d", i, e, x_bad); end
    end
  endtask

  task automatic test_random();
    int a, b, m, lat, bc, res, one, e, x_res, x_one, x_bad, x_lat;
    for (int i = 0; i < 40; i++) begin
      m = int'($urandom_range(255, 2));
      if (i % 5 == 4) begin
        a = int'($urandom_range(255, 0));
        b = int'($urandom_range(255, m));
        if (i % 10 == 9) m = int'($urandom_range(1, 0));
      end else begin
        a = int'($urandom_range(m - 1, 0));
        b = int'($urandom_range(m - 1, 0));
      end
      ref_model(a, b, m, x_res, x_one, x_bad, x_lat);
      do_op(a, b, m, lat, bc, res, one, e);
      n_cmp++;
      if (lat !== x_lat || res !== x_res || one !== x_one || e !== x_bad) begin
        n_bad++;
        $display("FAIL rand%0d a=%0d b=%0d m=%0d: got lat=%0d res=%0d one=%0d err=%0d want lat=%0d res=%0d one=%0d err=%0d",
                 i, a, b, m, lat, res, one, e, x_lat, x_res, x_one, x_bad);
      end
    end
  endtask

  task automatic test_handshake();
    int lat;
    data_a = 8'd3; data_b = 8'd5; data_m = 8'd7;
    start = 1'b1;
    tick();
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      if (done) begin lat = i; break; end
      data_a = W'($urandom_range(255, 0));
      data_b = W'($urandom_range(255, 0));
      data_m = W'($urandom_range(255, 0));
      tick();
    end
    n_cmp++; if (lat !== W + 1) begin n_bad++; $display("FAIL hs_latency: got %0d want %0d", lat, W + 1); end
    n_cmp++; if (result !== 8'd1 || is_one !== 1'b1) begin n_bad++; $display("FAIL hs_first_result: got %0d/%b want 1/1", result, is_one); end
    // Start still high through DONE; next request goes in the IDLE cycle after.
    data_a = 8'd5; data_b = 8'd6; data_m = 8'd13;
    tick();
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL hs_idle_after_done: got busy=%b done=%b want 0/0", busy, done); end
    n_cmp++; if (result !== 8'd1) begin n_bad++; $display("FAIL hs_hold_idle: got %0d want 1", result); end
    tick();
    start = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL hs_second_accept: got busy=%b want 1", busy); end
    n_cmp++; if (result !== 8'd1 || is_one !== 1'b1) begin n_bad++; $display("FAIL hs_hold_run: got %0d/%b want 1/1", result, is_one); end
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      if (done) begin lat = i; break; end
      tick();
    end
    n_cmp++; if (lat !== W + 1) begin n_bad++; $display("FAIL hs_second_latency: got %0d want %0d", lat, W + 1); end
    n_cmp++; if (result !== 8'd4 || is_one !== 1'b0) begin n_bad++; $display("FAIL hs_second_result: got %0d/%b want 4/0", result, is_one); end
    tick();
    tick();
    n_cmp++; if (result !== 8'd4) begin n_bad++; $display("FAIL hs_hold_after: got %0d want 4", result); end
  endtask

  task automatic test_reset_mid();
    int seen_done, lat, bc, res, one, e;
    data_a = 8'd3; data_b = 8'd5; data_m = 8'd7;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    #1;
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || result !== '0 || is_one !== 1'b0 || err !== 1'b0) begin
      n_bad++;
      $display("FAIL midrst_outputs: got busy=%b done=%b res=%0d one=%b err=%b want all 0", busy, done, result, is_one, err);
    end
    tick();
    rst = 1'b0;
    seen_done = 0;
    for (int i = 0; i < W + 4; i++) begin
      tick();
      if (done) seen_done++;
    end
    n_cmp++; if (seen_done !== 0) begin n_bad++; $display("FAIL midrst_no_done: got %0d pulses want 0", seen_done); end
    do_op(3, 5, 7, lat, bc, res, one, e);
    n_cmp++; if (lat !== W + 1 || res !== 1 || one !== 1 || e !== 0) begin
      n_bad++;
      $display("FAIL midrst_rerun: got lat=%0d res=%0d one=%0d err=%0d want %0d/1/1/0", lat, res, one, e, W + 1);
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_random();
    // Leave a nonzero result so the mid-run reset is visible.
    test_handshake();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
